// File: rtl/sobel_pkg.sv
// sobel_pkg: mode encodings and width helpers shared by the Sobel stream blocks
package sobel_pkg;
  typedef enum logic [1:0] {
    MODE_MAG = 2'd0,
    MODE_THR = 2'd1,
    MODE_GX  = 2'd2,
    MODE_GY  = 2'd3
  } mode_e;
  function automatic int sum_w(input int dw);
    return dw + 2;
  endfunction
  function automatic int grad_w(input int dw);
    return dw + 3;
  endfunction
  function automatic int sat_lim(input int dw);
    return (1 << dw) - 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head word
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = head_q;
  // next pointers/count; a push into a full FIFO lands only if a pop frees a slot
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_d  = cnt_d == '0 ? head_q : (do_push && wp_q == rp_d) ? din : mem[rp_d];
  end
  // storage array; never read before written, so no reset
  always_ff @(posedge clk)
    if (do_push) mem[wp_q] <= din;
  // pointer, count and head registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel engine with line buffers and an output FIFO
module sobel_stream import sobel_pkg::*; #(
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int DATA_W    = 8,
  parameter int OUT_DEPTH = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] pi_data,
  input  logic              pi_flag,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] thresh,
  output logic [DATA_W-1:0] po_data,
  output logic              po_flag,
  input  logic              po_ready,
  output logic              ovf,
  output logic              frame_done
);
  localparam int SW = sum_w(DATA_W);
  localparam int GW = grad_w(DATA_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [GW-1:0] LIM = GW'(sat_lim(DATA_W));
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic last_col, last_row;
  logic v0_q, v0_d, v1_q, v2_q, fd_q, fd_d, ovf_q, ovf_d;
  mode_e mode_q, mode_d, m1_q;
  logic [DATA_W-1:0] thr_q, thr_d, t1_q;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [SW-1:0] ax, ay;
  logic [DATA_W-1:0] sm, sx, sy, res_q, res_d;
  logic full, empty;
  function automatic logic [SW-1:0] sum3(input logic [DATA_W-1:0] a, b, c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction
  function automatic logic [DATA_W-1:0] sat(input logic [GW-1:0] v);
    return v > LIM ? DATA_W'(LIM) : DATA_W'(v);
  endfunction
  // raster counters, window shift, per-frame mode/thresh latch and frame-end pulse
  always_comb begin
    last_col = col_q == CW'(IMG_W - 1);
    last_row = row_q == RW'(IMG_H - 1);
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    mode_d   = mode_q;
    thr_d    = thr_q;
    if (pi_flag) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0[col_q];
      win_d[1][2] = lb1[col_q];
      win_d[2][2] = pi_data;
      mode_d = (col_q == '0 && row_q == '0) ? mode_e'(mode) : mode_q;
      thr_d  = (col_q == '0 && row_q == '0) ? thresh : thr_q;
    end
    v0_d = pi_flag && row_q >= RW'(2) && col_q >= CW'(2);
    fd_d = pi_flag && last_col && last_row;
  end
  // gradients from the freshly shifted window
  always_comb begin
    gx_d = $signed(GW'(sum3(win_q[0][2], win_q[1][2], win_q[2][2])))
         - $signed(GW'(sum3(win_q[0][0], win_q[1][0], win_q[2][0])));
    gy_d = $signed(GW'(sum3(win_q[2][0], win_q[2][1], win_q[2][2])))
         - $signed(GW'(sum3(win_q[0][0], win_q[0][1], win_q[0][2])));
  end
  // absolute values, saturation and mode selection; mode travels with the data
  always_comb begin
    ax    = gx_q[GW-1] ? SW'(-gx_q) : SW'(gx_q);
    ay    = gy_q[GW-1] ? SW'(-gy_q) : SW'(gy_q);
    sm    = sat(GW'(ax) + GW'(ay));
    sx    = sat(GW'(ax));
    sy    = sat(GW'(ay));
    res_d = m1_q == MODE_MAG ? sm :
            m1_q == MODE_THR ? (sm >= t1_q ? {DATA_W{1'b1}} : {DATA_W{1'b0}}) :
            m1_q == MODE_GX  ? sx : sy;
    ovf_d = ovf_q || (v2_q && full && !(po_ready && !empty));
  end
  // line buffers shift up one line per column: newest pixel in lb1, previous in lb0
  always_ff @(posedge sys_clk)
    if (pi_flag) begin
      lb0[col_q] <= lb1[col_q];
      lb1[col_q] <= pi_data;
    end
  // pipeline and control registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= '{default: '0};
      mode_q <= MODE_MAG;
      thr_q  <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      m1_q   <= MODE_MAG;
      t1_q   <= '0;
      res_q  <= '0;
      fd_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      mode_q <= mode_d;
      thr_q  <= thr_d;
      v0_q   <= v0_d;
      v1_q   <= v0_q;
      v2_q   <= v1_q;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      m1_q   <= mode_q;
      t1_q   <= thr_q;
      res_q  <= res_d;
      fd_q   <= fd_d;
      ovf_q  <= ovf_d;
    end
  end
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (v2_q),
    .din   (res_q),
    .pop   (po_ready),
    .dout  (po_data),
    .full  (full),
    .empty (empty)
  );
  assign po_flag    = !empty;
  assign ovf        = ovf_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed frames checked against a pixel-level Sobel model and literal results
module tb_sobel_stream;
  localparam int W = 4, H = 4, DEPTH = 2;
  logic sys_clk = 1'b0, sys_rst, pi_flag, po_flag, po_ready, ovf, frame_done;
  logic [7:0] pi_data, thresh, po_data;
  logic [1:0] mode;
  int checks = 0, errors = 0, fd_cnt = 0, k = 0, fd_due = -1, mrow = 0, mcol = 0;
  bit armed = 0, mfull, mpop, movf = 0;
  logic [1:0] mmode = 0;
  logic [7:0] mthr = 0;
  logic [7:0] img [H][W];
  typedef struct {int due; logic [7:0] val;} pend_t;
  pend_t pend[$];
  logic [7:0] mfifo[$];
  logic [7:0] got[$];

  sobel_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .OUT_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .mode(mode), .thresh(thresh), .po_data(po_data), .po_flag(po_flag),
    .po_ready(po_ready), .ovf(ovf), .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int satv(input int v);
    return v > 255 ? 255 : v;
  endfunction

  function automatic logic [7:0] model_px(input int r, input int c, input logic [1:0] md, input logic [7:0] th);
    int gx, gy, ax, ay, sm;
    gx = (int'(img[r-2][c]) + 2*int'(img[r-1][c]) + int'(img[r][c]))
       - (int'(img[r-2][c-2]) + 2*int'(img[r-1][c-2]) + int'(img[r][c-2]));
    gy = (int'(img[r][c-2]) + 2*int'(img[r][c-1]) + int'(img[r][c]))
       - (int'(img[r-2][c-2]) + 2*int'(img[r-2][c-1]) + int'(img[r-2][c]));
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    sm = satv(ax + ay);
    case (md)
      2'd0: return 8'(sm);
      2'd1: return sm >= int'(th) ? 8'hFF : 8'h00;
      2'd2: return 8'(satv(ax));
      default: return 8'(satv(ay));
    endcase
  endfunction

  // per-cycle compare against the model, then advance the model by what the next edge does
  always @(negedge sys_clk) begin
    k++;
    if (armed) begin
      chk("po_flag", po_flag, mfifo.size() > 0);
      if (mfifo.size() > 0) chk("po_data", po_data, mfifo[0]);
      chk("ovf", ovf, movf);
      chk("frame_done", frame_done, k == fd_due);
      if (frame_done === 1'b1) fd_cnt++;
      if (sys_rst) begin
        mrow = 0; mcol = 0; mmode = 0; mthr = 0; movf = 0; fd_due = -1;
        pend.delete();
        mfifo.delete();
      end else begin
        mfull = mfifo.size() == DEPTH;
        mpop  = mfifo.size() > 0 && po_ready;
        if (mpop) begin
          got.push_back(po_data);
          void'(mfifo.pop_front());
        end
        if (pend.size() > 0 && pend[0].due == k) begin
          if (mfull && !mpop) movf = 1;
          else mfifo.push_back(pend[0].val);
          void'(pend.pop_front());
        end
        if (pi_flag) begin
          img[mrow][mcol] = pi_data;
          if (mrow == 0 && mcol == 0) begin mmode = mode; mthr = thresh; end
          if (mrow >= 2 && mcol >= 2) pend.push_back('{k + 3, model_px(mrow, mcol, mmode, mthr)});
          if (mrow == H-1 && mcol == W-1) fd_due = k + 1;
          mrow = mcol == W-1 ? (mrow == H-1 ? 0 : mrow + 1) : mrow;
          mcol = mcol == W-1 ? 0 : mcol + 1;
        end
      end
    end
  end

  task automatic send(input int lo, input int hi, input int n, input int chg, input logic [1:0] cm);
    for (int i = 0; i < n; i++) begin
      if (i == chg) mode = cm;
      pi_data = (i % W) < 2 ? 8'(lo) : 8'(hi);
      pi_flag = 1'b1;
      @(posedge sys_clk); #1;
    end
    pi_flag = 1'b0;
  endtask

  task automatic chk_got(input string nm, input int from, input int to, input logic [7:0] v);
    for (int i = from; i < to; i++) chk(nm, i < got.size() ? got[i] : 8'hxx, v);
  endtask

  task automatic frame_test(input string nm, input int hi, input logic [1:0] md, input logic [7:0] th, input logic [7:0] v);
    mode = md; thresh = th; got.delete(); fd_cnt = 0;
    send(hi == 100 ? 100 : 0, hi, W*H, -1, 2'd0);
    repeat (10) @(posedge sys_clk);
    #1;
    chk({nm, "_count"}, got.size(), 4);
    chk_got({nm, "_val"}, 0, 4, v);
    chk({nm, "_fd"}, fd_cnt, 1);
  endtask

  initial begin
    sys_rst = 1; pi_flag = 0; pi_data = 0; mode = 0; thresh = 0; po_ready = 1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 0; armed = 1;
    @(negedge sys_clk);
    chk("rst_po_data", po_data, 0);
    chk("rst_po_flag", po_flag, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge sys_clk); #1;
    frame_test("const100_m0", 100, 2'd0, 8'd0, 8'h00);
    chk("const100_ovf", ovf, 0);
    frame_test("edge10_m0", 10, 2'd0, 8'd0, 8'h28);
    frame_test("edge10_m3", 10, 2'd3, 8'd0, 8'h00);
    frame_test("edge10_thr40", 10, 2'd1, 8'd40, 8'hFF);
    frame_test("edge10_thr41", 10, 2'd1, 8'd41, 8'h00);
    frame_test("edge200_m0", 200, 2'd0, 8'd0, 8'hFF);
    frame_test("edge200_m2", 200, 2'd2, 8'd0, 8'hFF);
    po_ready = 0; mode = 0; got.delete();
    send(0, 10, W*H, -1, 2'd0);
    repeat (10) @(posedge sys_clk);
    #1;
    chk("hold_po_flag", po_flag, 1);
    chk("hold_ovf", ovf, 1);
    po_ready = 1;
    repeat (6) @(posedge sys_clk);
    #1;
    chk("drain_count", got.size(), 2);
    chk_got("drain_val", 0, 2, 8'h28);
    chk("drain_po_flag", po_flag, 0);
    send(0, 10, 7, -1, 2'd0);
    sys_rst = 1;
    @(posedge sys_clk); #1;
    sys_rst = 0;
    chk("midrst_ovf", ovf, 0);
    chk("midrst_po_flag", po_flag, 0);
    frame_test("after_rst", 10, 2'd0, 8'd0, 8'h28);
    mode = 0; got.delete(); fd_cnt = 0;
    send(0, 10, 2*W*H, 5, 2'd3);
    repeat (10) @(posedge sys_clk);
    #1;
    chk("b2b_count", got.size(), 8);
    chk_got("b2b_frame1", 0, 4, 8'h28);
    chk_got("b2b_frame2", 4, 8, 8'h00);
    chk("b2b_fd", fd_cnt, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming 3x3 Sobel engine: next generation of the fixed 4x4 `sobel_ctrl`, placed between `uart_rx` and `uart_tx` in the top level.
- Accepts one pixel per `pi_flag` pulse in raster order for a frame of any `IMG_W` x `IMG_H`.
- Keeps two line buffers and a 3x3 window.
- Produces one result per interior pixel, (IMG_W-2)*(IMG_H-2) per frame, in one of four selectable modes.
- Buffers results in an output FIFO with valid/ready toward the transmitter and flags overflow.

## Interface
- `IMG_W`, 16: pixels per line, at least 3.
- `IMG_H`, 16: lines per frame, at least 3.
- `DATA_W`, 8: pixel and result width.
- `OUT_DEPTH`, 16: output FIFO depth, a power of 2, at least 2.

Ports (one clock, `sys_clk`; reset `sys_rst` is synchronous and active-high):
- `sys_clk`  in  1  clock.
- `sys_rst`  in  1  reset.
- `pi_data`  in  DATA_W  input pixel.
- `pi_flag`  in  1  pixel valid, single-cycle strobe; no backpressure.
- `mode`  in  2  output mode, 0 = |Gx|+|Gy|, 1 = binary threshold, 2 = |Gx|, 3 = |Gy|.
- `thresh`  in  DATA_W  threshold for mode 1.
- `po_data`  out  DATA_W  FIFO head.
- `po_flag`  out  1  FIFO not empty.
- `po_ready`  in  1  consumer accepts `po_data` this cycle.
- `ovf`  out  1  sticky, a result was dropped because the FIFO was full.
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is accepted.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each `pi_flag`.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_H-1, IMG_W-1) both wrap to 0, `frame_done` pulses, and the next pixel starts a new frame.
- Line buffers: each accepted pixel is written at `col` into the newest line; the older line shifts up. The window shifts one column per pixel.
- Window `p[r][c]`, r = 0 oldest line, c = 0 leftmost. The window is valid when the accepted pixel has row >= 2 and col >= 2; its centre is (row-1, col-1).
- Gx = (p02+2p12+p22) - (p00+2p10+p20). Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Sums use DATA_W+2 bits; differences are signed with DATA_W+3 bits.
  - Absolute values are unsigned DATA_W+2 bits; the magnitude sum is DATA_W+3 bits.
  - Modes 0, 2 and 3 saturate to 2^DATA_W-1.
- Mode 1 outputs all-ones if the saturated |Gx|+|Gy| >= thresh, else 0.
- `mode` and `thresh` are latched on the first pixel of each frame (row 0, col 0). Changes mid-frame are ignored until the next frame.
- FIFO:
  - A push is a valid result; a pop is `po_flag && po_ready`.
  - On push while full with no pop: drop the result and set `ovf`. `ovf` clears only on reset.
  - On push and pop in the same cycle while full: both happen and the count is unchanged.
  - A pop when empty is ignored.
- Reset:
  - Counters and the window clear, the FIFO empties, and the latched mode and thresh clear to 0.
  - Line-buffer RAM is not cleared, because the restarted row count masks stale data.
  - A reset mid-frame discards the partial frame. The next `pi_flag` is pixel (0,0).

## Timing
- Reset values: `po_data` 0, `po_flag` 0, `ovf` 0, `frame_done` 0.
- `frame_done` is registered and asserts in the cycle after the accepting `pi_flag`.
- Pipeline: cycle N `pi_flag` (window shift); N+1 Gx/Gy registered; N+2 abs, mode and saturation registered; N+3 FIFO write.
  - `po_flag` rises at N+4 when the FIFO was empty.
  - Latency from pixel to `po_flag` is 4 cycles.
- `pi_flag` may assert every cycle; throughput is one pixel per cycle.
- `po_data` is valid whenever `po_flag` is high and is stable until popped.

## Structure
- Package `sobel_pkg`:
  - Mode encodings `MODE_MAG`, `MODE_THR`, `MODE_GX`, `MODE_GY`.
  - Derived widths: sum width DATA_W+2, gradient width DATA_W+3.
  - The saturation limit.
- Sub-module `sync_fifo`: parameters width and depth; ports push/pop, full/empty, registered head. It is reused for other stream blocks.
- Line buffers are inferred RAM arrays inside `sobel_stream`.

## Test plan
All scenarios use IMG_W = IMG_H = 4 and DATA_W = 8.
- Constant 100 frame, mode 0, `po_ready` = 1 -> four results of 0x00; one `frame_done`; `ovf` = 0.
- Vertical edge (cols 0,1 = 0; cols 2,3 = 10):
  - mode 0 -> four results of 40 (0x28);
  - mode 3 -> four results of 0x00;
  - mode 1 with thresh 40 -> four results of 0xFF;
  - mode 1 with thresh 41 -> four results of 0x00.
- Edge with cols 2,3 = 200, mode 0 -> Gx = 800 saturates -> four results of 0xFF; mode 2 -> 0xFF.
- OUT_DEPTH = 2, `po_ready` = 0, one edge frame -> `po_flag` high, exactly 2 results held, `ovf` = 1. Then `po_ready` = 1 -> two 0x28 results, then `po_flag` = 0.
- Reset after 7 pixels, then a full edge frame -> exactly four 0x28 results; `frame_done` pulses once.
- Two back-to-back edge frames with `mode` changed 0 -> 3 at pixel 5 of frame 1 -> frame 1 results all 0x28; frame 2 results all 0x00.
